// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared states and frame constants for the instruction loader.
package inst_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_WIDTH = 8;
endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if: byte stream handshake plus instruction RAM write port.
interface inst_loader_if;
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master (input byte_in, byte_valid, output byte_ready, mem_we, mem_addr, mem_wdata);
  modport slave (output byte_in, byte_valid, input byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_word_packer.sv
// inst_word_packer: packs accepted bytes MSB-first into words, pulsing word_valid_o on the last byte.
module inst_word_packer import inst_loader_pkg::*; (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic accept_i,
  input  logic [7:0] byte_i,
  output logic [31:0] word_o,
  output logic word_valid_o
);
  logic [1:0] phase_q;
  logic [23:0] pack_q;
  // The final byte is merged combinationally so the word is ready on the accepting edge.
  assign word_o = {pack_q, byte_i};
  assign word_valid_o = accept_i && phase_q == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      phase_q <= '0;
      pack_q <= '0;
    end else if (accept_i) begin
      phase_q <= phase_q + 2'd1;
      pack_q <= word_o[23:0];
    end
  end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: parses a counted, checksummed byte frame and writes it into instruction RAM,
// holding the CPU until a load completes with a good checksum.
module inst_loader import inst_loader_pkg::*; #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  inst_loader_if.master bus,
  output logic cpu_hold,
  output logic done,
  output logic error
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
  state_t state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d;
  logic [CSUM_WIDTH-1:0] sum_q, sum_d;
  logic done_q, done_d, error_q, error_d, hold_q, hold_d;
  logic ready_q, we_q, start_ok, acc, word_valid;
  logic [31:0] word, addr_q, wdata_q;
  assign acc = bus.byte_valid && ready_q;
  assign bus.byte_ready = ready_q;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold = hold_q;
  assign done = done_q;
  assign error = error_q;
  inst_word_packer u_packer (
    .clock(clock),
    .reset(reset),
    .clear_i(start_ok),
    .accept_i(acc && state_q == DATA),
    .byte_i(bus.byte_in),
    .word_o(word),
    .word_valid_o(word_valid)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d = idx_q;
    sum_d = sum_q;
    done_d = done_q;
    error_d = error_q;
    hold_d = hold_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        start_ok = 1'b1;
        state_d = HDR_HI;
        count_d = '0;
        idx_d = '0;
        sum_d = '0;
        done_d = 1'b0;
        error_d = 1'b0;
        hold_d = 1'b1;
      end
      HDR_HI: if (acc) begin
        count_d[15:8] = bus.byte_in;
        sum_d = sum_q + bus.byte_in;
        state_d = HDR_LO;
      end
      HDR_LO: if (acc) begin
        count_d[7:0] = bus.byte_in;
        sum_d = sum_q + bus.byte_in;
        error_d = {1'b0, count_d} > CAP;
        state_d = error_d ? ERROR : count_d == 16'd0 ? CSUM : DATA;
      end
      DATA: if (acc) begin
        sum_d = sum_q + bus.byte_in;
        idx_d = word_valid ? idx_q + 1'b1 : idx_q;
        state_d = word_valid && 16'(idx_d) == count_q ? CSUM : DATA;
      end
      CSUM: if (acc) begin
        done_d = bus.byte_in == sum_q;
        error_d = !done_d;
        hold_d = !done_d;
        state_d = done_d ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      hold_q <= 1'b0;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      done_q <= done_d;
      error_q <= error_d;
      hold_q <= hold_d;
      ready_q <= state_d inside {HDR_HI, HDR_LO, DATA, CSUM};
      we_q <= word_valid;
      if (word_valid) begin
        addr_q <= 32'({idx_q, 2'b00});
        wdata_q <= word;
      end
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: frames built from word lists, expected writes and flags derived from the frame rules.
module tb_inst_loader;
  logic clock, reset, start, cpu_hold, done, error;
  int checks, errors;
  logic [7:0] frame[$];
  logic [31:0] words[$], wr_addr[$], wr_data[$];
  inst_loader_if bus ();
  inst_loader #(.ADDR_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (bus.mem_we) begin
    wr_addr.push_back(bus.mem_addr);
    wr_data.push_back(bus.mem_wdata);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'($urandom);
      @(negedge clock);
    end
    bus.byte_valid = 1'b1;
    bus.byte_in = b;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    bus.byte_valid = 1'b0;
    chk("accept_bound", 32'(t < 50), 32'd1);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask
  task automatic load(input logic [15:0] cnt, input bit bad, input bit gaps, input bit poke);
    logic [7:0] s;
    bit ovf, good;
    int n;
    ovf = cnt > 16'd256;
    good = !ovf && !bad;
    frame = {};
    frame.push_back(cnt[15:8]);
    frame.push_back(cnt[7:0]);
    if (!ovf) begin
      for (int i = 0; i < int'(cnt); i++)
        for (int k = 3; k >= 0; k--) frame.push_back(words[i][8*k +: 8]);
      s = 8'd0;
      foreach (frame[i]) s += frame[i];
      frame.push_back(bad ? s + 8'd1 : s);
    end
    pulse_start();
    chk("start_ready", 32'(bus.byte_ready), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    wr_addr = {};
    wr_data = {};
    foreach (frame[i]) begin
      send_byte(frame[i], gaps);
      if (poke && i == 4) pulse_start();
      if (i == frame.size() - 1) begin
        chk("done_timing", 32'(done), 32'(good));
        chk("error_timing", 32'(error), 32'(!good));
      end
    end
    repeat (3) @(negedge clock);
    n = ovf ? 0 : int'(cnt);
    chk("write_count", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk("write_addr", wr_addr[i], 32'(4 * i));
      chk("write_data", wr_data[i], words[i]);
    end
    chk("final_done", 32'(done), 32'(good));
    chk("final_error", 32'(error), 32'(!good));
    chk("final_hold", 32'(cpu_hold), 32'(!good));
    chk("final_ready", 32'(bus.byte_ready), 32'd0);
  endtask
  initial begin
    clock = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    words = {32'h78563412, 32'hEFBEADDE};
    load(16'd2, 1'b0, 1'b0, 1'b0);
    load(16'd2, 1'b1, 1'b0, 1'b0);
    load(16'h0101, 1'b0, 1'b0, 1'b0);
    load(16'd0, 1'b0, 1'b0, 1'b0);
    words = {};
    repeat (256) words.push_back($urandom);
    load(16'd256, 1'b0, 1'b0, 1'b0);
    chk("full_last_addr", wr_addr[wr_addr.size() - 1], 32'h3FC);
    words = {32'h78563412, 32'hEFBEADDE};
    load(16'd2, 1'b0, 1'b1, 1'b1);
    repeat (4) begin
      int n = $urandom_range(1, 12);
      words = {};
      repeat (n) words.push_back($urandom);
      load(16'(n), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    words = {$urandom, $urandom, $urandom};
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int k = 3; k >= 0; k--) send_byte(words[0][8*k +: 8], 1'b0);
    send_byte(words[1][31:24], 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset = 1'b0;
    load(16'd3, 1'b0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
